// File: rtl/uart_fifo.sv
// Circular byte FIFO between UART receiver and transmitter: valid/ready on both sides,
// occupancy and threshold flags, sticky overflow, synchronous flush, optional store-and-forward.
module uart_fifo #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int AF_LVL  = DEPTH - 2,
    parameter int AE_LVL  = 1,
    parameter int SF_MODE = 0,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              overflow,
    output logic              fsm_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits on ready, and ready/valid here are decoded from registered state only.

    localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AF_CNT   = AF_LVL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_CNT   = AE_LVL[ADDR_W:0];

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q;
    logic              wr_fire, rd_fire;

    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign almost_full  = (count_q >= AF_CNT);
    assign overflow     = overflow_q;
    assign fsm_state    = (state_q == DRAIN);

    // No full-bypass: a read in the same cycle does not reopen the write side.
    assign s_ready = !full;
    assign m_valid = (SF_MODE == 0) ? !empty : ((state_q == DRAIN) && !empty);
    assign m_data  = m_valid ? mem[rd_ptr] : '0;

    assign wr_fire = s_valid && s_ready && !flush;
    assign rd_fire = m_valid && m_ready && !flush;

    always_comb begin
        count_d = count_q;
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL:    if (count_d == FULL_CNT) state_d = DRAIN;
                DRAIN:   if (count_d == '0)       state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= FILL;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= FILL;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            if (s_valid && full) overflow_q <= 1'b1;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo: a streaming and a store-and-forward instance share one stimulus stream
// and are each compared every cycle against a queue-based reference.
module tb_uart_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 1;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       flush = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       m_ready = 1'b0;

    logic       s_ready_a, m_valid_a, empty_a, full_a, ae_a, af_a, ovf_a, st_a;
    logic [7:0] m_data_a;
    logic [4:0] count_a;
    logic       s_ready_b, m_valid_b, empty_b, full_b, ae_b, af_b, ovf_b, st_b;
    logic [7:0] m_data_b;
    logic [4:0] count_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: contents as plain queues, sticky overflow, store-and-forward draining flag.
    logic [7:0] exp_q[$];
    logic [7:0] exp_sf_q[$];
    logic       exp_ovf, exp_sf_ovf, exp_drain;

    uart_fifo #(.DATA_W(8), .DEPTH(DEPTH), .AF_LVL(AF), .AE_LVL(AE), .SF_MODE(0)) u_dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_a),
        .m_valid(m_valid_a), .m_data(m_data_a), .m_ready(m_ready),
        .count(count_a), .empty(empty_a), .full(full_a),
        .almost_empty(ae_a), .almost_full(af_a), .overflow(ovf_a), .fsm_state(st_a)
    );

    uart_fifo #(.DATA_W(8), .DEPTH(DEPTH), .AF_LVL(AF), .AE_LVL(AE), .SF_MODE(1)) u_dut_sf (
        .clk(clk), .rstn(rstn), .flush(flush),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_b),
        .m_valid(m_valid_b), .m_data(m_data_b), .m_ready(m_ready),
        .count(count_b), .empty(empty_b), .full(full_b),
        .almost_empty(ae_b), .almost_full(af_b), .overflow(ovf_b), .fsm_state(st_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_sf_q.delete();
        exp_ovf    = 1'b0;
        exp_sf_ovf = 1'b0;
        exp_drain  = 1'b0;
    endtask

    // Apply one clock's worth of the FIFO rules to the reference, given this cycle's inputs.
    task automatic model_step(input logic sv, input logic [7:0] sd, input logic mr, input logic fl);
        logic mv;
        if (fl) begin
            model_reset();
            return;
        end
        mv = exp_q.size() > 0;
        if (sv && exp_q.size() == DEPTH) exp_ovf = 1'b1;
        if (mv && mr) void'(exp_q.pop_front());
        if (sv && exp_q.size() + ((mv && mr) ? 1 : 0) < DEPTH + 0 && !(exp_q.size() + ((mv && mr) ? 1 : 0) == DEPTH))
            exp_q.push_back(sd);

        mv = exp_drain && exp_sf_q.size() > 0;
        if (sv && exp_sf_q.size() == DEPTH) exp_sf_ovf = 1'b1;
        begin
            bit was_full = exp_sf_q.size() == DEPTH;
            if (mv && mr) void'(exp_sf_q.pop_front());
            if (sv && !was_full) exp_sf_q.push_back(sd);
        end
        if (!exp_drain && exp_sf_q.size() == DEPTH) exp_drain = 1'b1;
        else if (exp_drain && exp_sf_q.size() == 0) exp_drain = 1'b0;
    endtask

    task automatic compare_all();
        int n;
        logic mv;
        n = exp_q.size();
        check("count", 32'(count_a), n);
        check("empty", 32'(empty_a), 32'(n == 0));
        check("full", 32'(full_a), 32'(n == DEPTH));
        check("almost_empty", 32'(ae_a), 32'(n <= AE));
        check("almost_full", 32'(af_a), 32'(n >= AF));
        check("s_ready", 32'(s_ready_a), 32'(n != DEPTH));
        check("overflow", 32'(ovf_a), 32'(exp_ovf));
        check("m_valid", 32'(m_valid_a), 32'(n > 0));
        check("m_data", 32'(m_data_a), (n > 0) ? 32'(exp_q[0]) : 32'd0);

        n  = exp_sf_q.size();
        mv = exp_drain && n > 0;
        check("sf_count", 32'(count_b), n);
        check("sf_full", 32'(full_b), 32'(n == DEPTH));
        check("sf_s_ready", 32'(s_ready_b), 32'(n != DEPTH));
        check("sf_overflow", 32'(ovf_b), 32'(exp_sf_ovf));
        check("sf_state", 32'(st_b), 32'(exp_drain));
        check("sf_m_valid", 32'(m_valid_b), 32'(mv));
        check("sf_m_data", 32'(m_data_b), mv ? 32'(exp_sf_q[0]) : 32'd0);
    endtask

    // Drive inputs on the falling edge, update the reference, then check just after the rising edge.
    task automatic cycle(input logic sv, input logic [7:0] sd, input logic mr, input logic fl);
        @(negedge clk);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        model_step(sv, sd, mr, fl);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        int bias;
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        rstn = 1'b1;

        // In-order transfer of 15 words, then drain.
        for (int i = 0; i < 15; i++) cycle(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Fill to full, overflow attempt, hold while full, flush.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        idle();
        cycle(1'b1, 8'hEF, 1'b1, 1'b0);
        cycle(1'b1, 8'hF0, 1'b1, 1'b1);
        idle();

        // Steady-state simultaneous read/write at count 5, wrapping the pointers.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        for (int i = 0; i < 2 * DEPTH + 3; i++) cycle(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Store-and-forward cycle: fill, drain completely, then a single write stays held.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Randomized traffic with shifting write/read bias and occasional flush.
        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) bias = $urandom_range(20, 80);
            cycle(1'($urandom_range(0, 99) < bias), 8'($urandom),
                  1'($urandom_range(0, 99) >= bias), 1'($urandom_range(0, 99) == 0));
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset mid-write at count 7.
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'hCC;
        #2;
        rstn = 1'b0;
        #1;
        check("arst_count", 32'(count_a), 32'd0);
        check("arst_m_valid", 32'(m_valid_a), 32'd0);
        check("arst_s_ready", 32'(s_ready_a), 32'd1);
        check("arst_sf_count", 32'(count_b), 32'd0);
        model_reset();
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rstn = 1'b1;
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        check("arst_readback", 32'(m_data_a), 32'h3C);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_fifo.md
# uart_fifo

Parametrised byte-stream buffer between the UART receiver and transmitter, replacing the fixed 8x8 buffer. It is a circular FIFO of DEPTH words of DATA_W bits with valid/ready handshakes on both sides. It reports occupancy, threshold flags and a sticky overflow flag. A synchronous flush empties it, and an optional store-and-forward mode holds output until the buffer has filled.

## Interface
- DATA_W, 8, word width in bits.
- DEPTH, 16, number of entries; power of two, at least 2. ADDR_W = clog2(DEPTH).
- AF_LVL, DEPTH-2, almost_full asserts when count >= AF_LVL.
- AE_LVL, 1, almost_empty asserts when count <= AE_LVL.
- SF_MODE, 0, 0 = streaming; 1 = store-and-forward (fill, then drain).
- clk  in  1  single clock; all logic is rising-edge.
- rstn  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of contents, pointers, overflow and the mode FSM.
- s_valid  in  1  write request from the UART receiver.
- s_data  in  DATA_W  write data.
- s_ready  out  1  write accept, equal to !full.
- m_valid  out  1  read data available.
- m_data  out  DATA_W  head-of-queue word (first-word fall-through).
- m_ready  in  1  read accept from the UART transmitter.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_LVL.
- almost_full  out  1  count >= AF_LVL.
- overflow  out  1  sticky; set when a write is attempted while full.

## Operation
- Storage is an array mem[0:DEPTH-1] with registers wr_ptr and rd_ptr (ADDR_W bits each) and a count register. The pointers wrap naturally from DEPTH-1 to 0.
- Write fires when s_valid && s_ready: mem[wr_ptr] <= s_data, wr_ptr increments.
- Read fires when m_valid && m_ready: rd_ptr increments.
- count update: +1 on write only, -1 on read only, unchanged when both or neither fire.
- Simultaneous write and read at 0 < count < DEPTH: both are performed and count is unchanged.
- When full, s_ready = 0 even if a read fires in the same cycle; there is no full-bypass.
- When empty, there is no read-through; a written word appears on m_data the next cycle.
- Write while full (s_valid=1, full=1): the data is dropped, pointers are unchanged, and overflow <= 1.
- m_ready while m_valid=0 is ignored; there is no underflow state.
- m_data = mem[rd_ptr] whenever m_valid=1, and is forced to 0 when m_valid=0.
- flush has priority over a same-cycle write or read. Next cycle: count=0, pointers=0, overflow=0, FSM=FILL. Memory contents are not cleared.
- SF_MODE=0: m_valid = !empty.
- SF_MODE=1: two-state FSM.
  - FILL: m_valid=0; writes are accepted. Moves to DRAIN on the edge where count becomes DEPTH.
  - DRAIN: m_valid = !empty; writes are still accepted while not full. Returns to FILL on the edge where count becomes 0.
- Reset values: count=0, wr_ptr=rd_ptr=0, empty=1, full=0, almost_empty=1 (AE_LVL >= 0), almost_full=0, overflow=0, s_ready=1, m_valid=0, m_data=0, FSM=FILL.

## Timing
- All flags and count are registered, or decoded combinationally from the registered count and FSM. They change only on a rising clk edge or on assertion of rstn.
- Write-to-output latency (SF_MODE=0): a write accepted at edge N gives m_valid=1 and valid m_data after edge N, so the word can be consumed at edge N+1.
- SF_MODE=1: m_valid rises in the cycle after the edge that made count = DEPTH.
- Full flag: s_ready falls in the cycle after the edge that wrote the DEPTH-th word, and rises in the cycle after the first read from full.
- Asynchronous reset mid-transfer aborts immediately. A handshake in progress is not completed and the outputs take their reset values without waiting for clk.

## Test plan
- Reset, then write 0x11..0x1F (15 words, DEPTH=16), then read all -> reads return the same order; count goes 15 -> 0; empty=1 at the end.
- Write 16 words -> full=1, s_ready=0. A 17th write with s_valid=1 -> data dropped, overflow=1 (sticky), count=16. flush -> overflow=0, count=0.
- At count=5, assert s_valid and m_ready together for 10 cycles -> count stays 5 and the output sequence is continuous. Across >DEPTH words, pointer wrap yields no duplicates or skips.
- Thresholds at AF_LVL=14, AE_LVL=1 -> almost_full rises exactly when count=14; almost_empty falls exactly when count=2.
- SF_MODE=1: write 15 words -> m_valid stays 0. 16th write -> m_valid=1 next cycle. Drain 16 words -> FSM returns to FILL; a subsequent single write keeps m_valid=0.
- Drop rstn asynchronously at count=7 during a write -> count=0, m_valid=0 and s_ready=1 immediately. After release, the first write reads back correctly.
